// File: rtl/aes_pkg.sv
// Shared AES constants, InvMixColumns FSM state type and GF(2^8) xtime helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Used by inv_mix_col, inv_mix_columns_seq and inv_mix_columns_seq_if.
// Optional feature macro consumed by users of this package: INV_MIX_FWD_EN.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_COL_W   = 32;
  localparam int AES_BYTE_W  = 8;
  localparam int AES_NCOLS   = AES_STATE_W / AES_COL_W;

  // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1.
  localparam logic [AES_BYTE_W-1:0] GF_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } imc_state_e;

  // Multiply by x (0x02) in GF(2^8).
  function automatic logic [AES_BYTE_W-1:0] xtime(input logic [AES_BYTE_W-1:0] b);
    xtime = {b[AES_BYTE_W-2:0], 1'b0} ^ (b[AES_BYTE_W-1] ? GF_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/inv_mix_columns_seq_if.sv
// Handshake bundle for inv_mix_columns_seq: input state channel and output state channel.
// Latency: n/a (signal bundle only).
// Backpressure: valid/ready on both channels; data held by the sender until accepted.
// Signals: in_valid/in_ready/input_s (source -> block), out_valid/out_ready/output_s
// (block -> sink), plus fwd (source -> block) when INV_MIX_FWD_EN is defined.
// Modports: master = source/sink side, slave = the transform block.
interface inv_mix_columns_seq_if;
  import aes_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [AES_STATE_W-1:0] input_s;
  logic                   out_valid;
  logic                   out_ready;
  logic [AES_STATE_W-1:0] output_s;
`ifdef INV_MIX_FWD_EN
  logic                   fwd;

  modport master (
    output in_valid, input_s, out_ready, fwd,
    input  in_ready, out_valid, output_s
  );

  modport slave (
    input  in_valid, input_s, out_ready, fwd,
    output in_ready, out_valid, output_s
  );
`else
  modport master (
    output in_valid, input_s, out_ready,
    input  in_ready, out_valid, output_s
  );

  modport slave (
    input  in_valid, input_s, out_ready,
    output in_ready, out_valid, output_s
  );
`endif

endinterface

// File: rtl/inv_mix_col.sv
// One-column AES InvMixColumns (circulant 0E 0B 0D 09), or forward MixColumns when selected.
// Latency: combinational, 0 cycles.
// Backpressure: none; pure function of its inputs.
// Ports: col_i (32-bit column, a0 in the top byte), col_o (32-bit result, same layout),
// fwd (1 = forward MixColumns 02 03 01 01) only when INV_MIX_FWD_EN is defined.
module inv_mix_col
  import aes_pkg::*;
(
`ifdef INV_MIX_FWD_EN
  input  logic                 fwd,
`endif
  input  logic [AES_COL_W-1:0] col_i,
  output logic [AES_COL_W-1:0] col_o
);

  // Element i is column byte a_i (i = 0 is the top byte of the column).
  logic [3:0][AES_BYTE_W-1:0] a, x2, x4, x8;
  logic [3:0][AES_BYTE_W-1:0] m09, m0b, m0d, m0e;
  logic [3:0][AES_BYTE_W-1:0] inv_b;

  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign a[i]  = col_i[AES_COL_W-1-AES_BYTE_W*i -: AES_BYTE_W];
    assign x2[i] = xtime(a[i]);
    assign x4[i] = xtime(x2[i]);
    assign x8[i] = xtime(x4[i]);

    assign m09[i] = x8[i] ^ a[i];
    assign m0b[i] = x8[i] ^ x2[i] ^ a[i];
    assign m0d[i] = x8[i] ^ x4[i] ^ a[i];
    assign m0e[i] = x8[i] ^ x4[i] ^ x2[i];

    // Row i of the circulant is the base row rotated right by i.
    assign inv_b[i] = m0e[i] ^ m0b[(i+1)%4] ^ m0d[(i+2)%4] ^ m09[(i+3)%4];

`ifdef INV_MIX_FWD_EN
    logic [AES_BYTE_W-1:0] fwd_b;
    // 03*a = xtime(a) ^ a, so forward mode reuses the x2 stage.
    assign fwd_b = x2[i] ^ (x2[(i+1)%4] ^ a[(i+1)%4]) ^ a[(i+2)%4] ^ a[(i+3)%4];
    assign col_o[AES_COL_W-1-AES_BYTE_W*i -: AES_BYTE_W] = fwd ? fwd_b : inv_b[i];
`else
    assign col_o[AES_COL_W-1-AES_BYTE_W*i -: AES_BYTE_W] = inv_b[i];
`endif
  end

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Column-serial AES InvMixColumns over a 128-bit state, COLS_PER_CYCLE columns per cycle.
// Latency: 4/COLS_PER_CYCLE cycles accept-to-out_valid; one state per 4/COLS_PER_CYCLE+1 cycles.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE or DONE&out_ready.
// Ports: clk, rst (sync, active-high), bus (inv_mix_columns_seq_if.slave: in_valid/in_ready/
// input_s, out_valid/out_ready/output_s, plus fwd when INV_MIX_FWD_EN is defined).
// Optional feature: INV_MIX_FWD_EN adds a per-state fwd select (forward MixColumns).
module inv_mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
)(
  input  logic                  clk,
  input  logic                  rst,
  inv_mix_columns_seq_if.slave  bus
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
    $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam int         N        = COLS_PER_CYCLE;
  localparam logic [1:0] LAST_COL = 2'(AES_NCOLS - N);
  localparam logic [1:0] COL_STEP = 2'(N);

  // Column c of the state lives in packed element 3-c, so element index = ~c for a 2-bit c.
  typedef logic [AES_NCOLS-1:0][AES_COL_W-1:0] state_cols_t;

  imc_state_e  state_q, state_d;
  logic [1:0]  col_q, col_d;
  state_cols_t work_q, work_d;
  state_cols_t out_s_q, out_s_d;
  logic        out_valid_q, out_valid_d;
  logic        in_ready;
  logic        accept;
`ifdef INV_MIX_FWD_EN
  logic        fwd_q, fwd_d;
`endif

  logic [1:0]           grp_col [N];
  logic [AES_COL_W-1:0] grp_in  [N];
  logic [AES_COL_W-1:0] grp_out [N];

  for (genvar g = 0; g < N; g++) begin : g_col
    assign grp_col[g] = col_q + 2'(g);
    assign grp_in[g]  = work_q[~grp_col[g]];

    inv_mix_col u_col (
`ifdef INV_MIX_FWD_EN
      .fwd   (fwd_q),
`endif
      .col_i (grp_in[g]),
      .col_o (grp_out[g])
    );
  end

  always_comb begin
    in_ready    = !rst && ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));
    accept      = in_ready && bus.in_valid;

    state_d     = state_q;
    col_d       = col_q;
    work_d      = work_q;
    out_s_d     = out_s_q;
    out_valid_d = out_valid_q;
`ifdef INV_MIX_FWD_EN
    fwd_d       = fwd_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          work_d  = bus.input_s;
          col_d   = '0;
          state_d = BUSY;
`ifdef INV_MIX_FWD_EN
          fwd_d   = bus.fwd;
`endif
        end
      end

      BUSY: begin
        for (int g = 0; g < N; g++) begin
          work_d[~grp_col[g]] = grp_out[g];
        end
        if (col_q == LAST_COL) begin
          col_d       = '0;
          state_d     = DONE;
          out_s_d     = work_d;
          out_valid_d = 1'b1;
        end else begin
          col_d = col_q + COL_STEP;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (accept) begin
            // Back-to-back: next state enters in the same cycle the result leaves.
            work_d  = bus.input_s;
            col_d   = '0;
            state_d = BUSY;
`ifdef INV_MIX_FWD_EN
            fwd_d   = bus.fwd;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= '0;
      work_q      <= '0;
      out_s_q     <= '0;
      out_valid_q <= 1'b0;
`ifdef INV_MIX_FWD_EN
      fwd_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      work_q      <= work_d;
      out_s_q     <= out_s_d;
      out_valid_q <= out_valid_d;
`ifdef INV_MIX_FWD_EN
      fwd_q       <= fwd_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.output_s  = out_s_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Self-checking bench for inv_mix_columns_seq with COLS_PER_CYCLE = 1, 2 and 4 side by side.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench); forward/round-trip cases need INV_MIX_FWD_EN.
`timescale 1ns/1ps
module tb_inv_mix_columns_seq;

  typedef struct {
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Index 0: N=1, index 1: N=2, index 2: N=4.
  logic         tb_in_valid  [3];
  logic [127:0] tb_input_s   [3];
  logic         tb_out_ready [3];
  logic         tb_in_ready  [3];
  logic         tb_out_valid [3];
  logic [127:0] tb_output_s  [3];
`ifdef INV_MIX_FWD_EN
  logic         tb_fwd       [3];
`endif

  inv_mix_columns_seq_if if_n1 ();
  inv_mix_columns_seq_if if_n2 ();
  inv_mix_columns_seq_if if_n4 ();

  assign if_n1.in_valid  = tb_in_valid[0];
  assign if_n1.input_s   = tb_input_s[0];
  assign if_n1.out_ready = tb_out_ready[0];
  assign tb_in_ready[0]  = if_n1.in_ready;
  assign tb_out_valid[0] = if_n1.out_valid;
  assign tb_output_s[0]  = if_n1.output_s;

  assign if_n2.in_valid  = tb_in_valid[1];
  assign if_n2.input_s   = tb_input_s[1];
  assign if_n2.out_ready = tb_out_ready[1];
  assign tb_in_ready[1]  = if_n2.in_ready;
  assign tb_out_valid[1] = if_n2.out_valid;
  assign tb_output_s[1]  = if_n2.output_s;

  assign if_n4.in_valid  = tb_in_valid[2];
  assign if_n4.input_s   = tb_input_s[2];
  assign if_n4.out_ready = tb_out_ready[2];
  assign tb_in_ready[2]  = if_n4.in_ready;
  assign tb_out_valid[2] = if_n4.out_valid;
  assign tb_output_s[2]  = if_n4.output_s;

`ifdef INV_MIX_FWD_EN
  assign if_n1.fwd = tb_fwd[0];
  assign if_n2.fwd = tb_fwd[1];
  assign if_n4.fwd = tb_fwd[2];
`endif

  inv_mix_columns_seq #(.COLS_PER_CYCLE(1)) dut_n1 (.clk(clk), .rst(rst), .bus(if_n1));
  inv_mix_columns_seq #(.COLS_PER_CYCLE(2)) dut_n2 (.clk(clk), .rst(rst), .bus(if_n2));
  inv_mix_columns_seq #(.COLS_PER_CYCLE(4)) dut_n4 (.clk(clk), .rst(rst), .bus(if_n4));

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 4 : (k == 1) ? 2 : 1;
  endfunction

  // Called at a negedge. Offers din, waits for accept, then scrambles input_s so a
  // design that keeps sampling it gets the wrong answer. Returns the produced state.
  task automatic run_tx(input int k, input logic [127:0] din, input logic [127:0] exp,
                        input bit cmp, input string name, input bit release_out,
                        output logic [127:0] got);
    int n;
    tb_in_valid[k] = 1'b1;
    tb_input_s[k]  = din;
    n = 0;
    while (!tb_in_ready[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("%s accept", name), 128'(tb_in_ready[k]), 128'(1));
    @(negedge clk);
    tb_in_valid[k] = 1'b0;
    tb_input_s[k]  = ~din;
    n = 0;
    while (!tb_out_valid[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("%s latency", name), 128'(n), 128'(lat_of(k)));
    got = tb_output_s[k];
    if (cmp) chk($sformatf("%s data", name), got, exp);
    if (release_out) begin
      tb_out_ready[k] = 1'b1;
      @(negedge clk);
      tb_out_ready[k] = 1'b0;
      chk($sformatf("%s out_valid after release", name), 128'(tb_out_valid[k]), 128'(0));
      chk($sformatf("%s in_ready after release", name), 128'(tb_in_ready[k]), 128'(1));
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: time %0t reached, required finish before 5000000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t         vecs [3];
    logic [127:0] got;
    logic [127:0] held;
    int           n;

    vecs[0].din = 128'h8e4da1bc_01010101_01010101_01010101;
    vecs[0].exp = 128'hdb135345_01010101_01010101_01010101;
    vecs[1].din = 128'hd5d5d7d6_4d7ebdf8_c6c6c6c6_9fdc589d;
    vecs[1].exp = 128'hd4d4d4d5_2d26314c_c6c6c6c6_f20a225c;
    // Unit columns pick out matrix columns; 0x80 exercises every reduction; ff..ff is a fixed point.
    vecs[2].din = 128'h01000000_00000001_80000000_ffffffff;
    vecs[2].exp = 128'h0e090d0b_090d0b0e_41ecdaf7_ffffffff;

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tb_in_valid[k]  = 1'b0;
      tb_input_s[k]   = '0;
      tb_out_ready[k] = 1'b0;
`ifdef INV_MIX_FWD_EN
      tb_fwd[k]       = 1'b0;
`endif
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("n%0d reset out_valid", k), 128'(tb_out_valid[k]), 128'(0));
      chk($sformatf("n%0d reset output_s", k), tb_output_s[k], 128'(0));
      chk($sformatf("n%0d reset in_ready", k), 128'(tb_in_ready[k]), 128'(0));
    end
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("n%0d idle in_ready", k), 128'(tb_in_ready[k]), 128'(1));
    end

    // Vector table against every column width.
    for (int k = 0; k < 3; k++) begin
      for (int v = 0; v < 3; v++) begin
        run_tx(k, vecs[v].din, vecs[v].exp, 1'b1, $sformatf("n%0d vec%0d", k, v), 1'b1, got);
      end
    end

    // Backpressure: result must sit still in DONE, then a back-to-back accept.
    run_tx(0, vecs[1].din, vecs[1].exp, 1'b1, "bp", 1'b0, got);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("bp hold output_s c%0d", c), tb_output_s[0], vecs[1].exp);
      chk($sformatf("bp hold in_ready c%0d", c), 128'(tb_in_ready[0]), 128'(0));
    end
    chk("bp hold out_valid", 128'(tb_out_valid[0]), 128'(1));
    tb_out_ready[0] = 1'b1;
    tb_in_valid[0]  = 1'b1;
    tb_input_s[0]   = vecs[0].din;
    #1;
    chk("b2b in_ready", 128'(tb_in_ready[0]), 128'(1));
    @(negedge clk);
    tb_out_ready[0] = 1'b0;
    tb_in_valid[0]  = 1'b0;
    tb_input_s[0]   = '0;
    chk("b2b out_valid dropped", 128'(tb_out_valid[0]), 128'(0));
    chk("b2b busy in_ready", 128'(tb_in_ready[0]), 128'(0));
    n = 0;
    while (!tb_out_valid[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2b latency", 128'(n), 128'(4));
    chk("b2b data", tb_output_s[0], vecs[0].exp);
    held = tb_output_s[0];

    // Reset on the second BUSY cycle discards the state in flight.
    tb_out_ready[0] = 1'b1;
    @(negedge clk);
    tb_out_ready[0] = 1'b0;
    tb_in_valid[0]  = 1'b1;
    tb_input_s[0]   = vecs[2].din;
    @(negedge clk);
    tb_in_valid[0]  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst out_valid", 128'(tb_out_valid[0]), 128'(0));
    chk("rst output_s", tb_output_s[0], 128'(0));
    chk("rst in_ready", 128'(tb_in_ready[0]), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst idle in_ready", 128'(tb_in_ready[0]), 128'(1));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("post-rst no result c%0d", c), 128'(tb_out_valid[0]), 128'(0));
    end
    chk("pre-rst result was real", held, vecs[0].exp);
    run_tx(0, vecs[1].din, vecs[1].exp, 1'b1, "post-rst vec1", 1'b1, got);

`ifdef INV_MIX_FWD_EN
    begin
      logic [127:0] mid;
      logic [127:0] r;
      tb_fwd[0] = 1'b1;
      run_tx(0, vecs[0].exp, vecs[0].din, 1'b1, "fwd fips", 1'b1, mid);
      tb_fwd[0] = 1'b0;
      run_tx(0, mid, vecs[0].exp, 1'b1, "fwd fips back", 1'b1, got);
      tb_fwd[2] = 1'b1;
      run_tx(2, vecs[1].exp, vecs[1].din, 1'b1, "n4 fwd vec1", 1'b1, got);
      tb_fwd[2] = 1'b0;
      for (int i = 0; i < 1000; i++) begin
        r = {$urandom, $urandom, $urandom, $urandom};
        tb_fwd[0] = 1'b1;
        run_tx(0, r, '0, 1'b0, $sformatf("rt%0d fwd", i), 1'b1, mid);
        tb_fwd[0] = 1'b0;
        run_tx(0, mid, r, 1'b1, $sformatf("rt%0d inv", i), 1'b1, got);
      end
    end
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
